// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side instruction fields, hazard controls, forwarding
// sources, and the operands presented to the ALU.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              id_alusrc;
  logic [1:0]        id_alu_ctrl;
  logic              id_regwrite;
  logic              stall;
  logic              flush;
  logic              exmem_regwrite;
  logic [4:0]        exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_regwrite;
  logic [4:0]        memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic              ALU_OverFlow;
  logic [DATA_W-1:0] ALU_DA;
  logic [DATA_W-1:0] ALU_DB;
  logic [1:0]        ALU_Ctrl;
  logic              ex_valid;
  logic [4:0]        ex_rd;
  logic [DATA_W-1:0] ex_store_data;
  logic              ex_wb_en;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alusrc, id_alu_ctrl, id_regwrite, stall, flush,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result, ALU_OverFlow,
    input  ALU_DA, ALU_DB, ALU_Ctrl, ex_valid, ex_rd, ex_store_data, ex_wb_en
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alusrc, id_alu_ctrl, id_regwrite, stall, flush,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result, ALU_OverFlow,
    output ALU_DA, ALU_DB, ALU_Ctrl, ex_valid, ex_rd, ex_store_data, ex_wb_en
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, EX/MEM and MEM/WB operand
// forwarding, and overflow-qualified register write enable.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_OR  = 2'b01,
    ALU_SUB = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              alusrc;
    logic [1:0]        alu_ctrl;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } stage_t;

  stage_t            stage_q, stage_d;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic              arith_op;

  // All-zero bubble doubles as the reset value: alu_ctrl 2'b00 is ADD.
  always_comb begin
    stage_d = stage_q;
    if (bus.flush) begin
      stage_d = '0;
    end else if (!bus.stall) begin
      stage_d.valid    = bus.id_valid;
      stage_d.regwrite = bus.id_regwrite;
      stage_d.alusrc   = bus.id_alusrc;
      stage_d.alu_ctrl = bus.id_alu_ctrl;
      stage_d.rs       = bus.id_rs;
      stage_d.rt       = bus.id_rt;
      stage_d.rd       = bus.id_rd;
      stage_d.rs_data  = bus.id_rs_data;
      stage_d.rt_data  = bus.id_rt_data;
      stage_d.imm      = bus.id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  // EX/MEM wins over MEM/WB; register 0 is never forwarded.
  function automatic logic [DATA_W-1:0] forward(
    input logic [4:0]        reg_num,
    input logic [DATA_W-1:0] stored,
    input logic              exmem_we,
    input logic [4:0]        exmem_dst,
    input logic [DATA_W-1:0] exmem_val,
    input logic              memwb_we,
    input logic [4:0]        memwb_dst,
    input logic [DATA_W-1:0] memwb_val
  );
    if (exmem_we && (exmem_dst != 5'd0) && (exmem_dst == reg_num))
      return exmem_val;
    else if (memwb_we && (memwb_dst != 5'd0) && (memwb_dst == reg_num))
      return memwb_val;
    else
      return stored;
  endfunction

  always_comb begin
    rs_fwd = forward(stage_q.rs, stage_q.rs_data,
                     bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                     bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result);
    rt_fwd = forward(stage_q.rt, stage_q.rt_data,
                     bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                     bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result);
    arith_op = (stage_q.alu_ctrl == ALU_ADD) || (stage_q.alu_ctrl == ALU_SUB);
  end

  assign bus.ALU_DA        = rs_fwd;
  assign bus.ALU_DB        = stage_q.alusrc ? stage_q.imm : rt_fwd;
  assign bus.ALU_Ctrl      = stage_q.alu_ctrl;
  assign bus.ex_store_data = rt_fwd;
  assign bus.ex_valid      = stage_q.valid;
  assign bus.ex_rd         = stage_q.rd;
  assign bus.ex_wb_en      = stage_q.valid & stage_q.regwrite &
                             ~(bus.ALU_OverFlow & arith_op);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32)) bus ();
  id_ex_stage #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic asrc, input logic [1:0] ctrl,
                        input logic rw);
    bus.id_valid = v;     bus.id_rs = rs;        bus.id_rt = rt;    bus.id_rd = rd;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd;  bus.id_imm = imm;
    bus.id_alusrc = asrc; bus.id_alu_ctrl = ctrl; bus.id_regwrite = rw;
  endtask

  task automatic clear_fwd();
    bus.exmem_regwrite = 1'b0; bus.exmem_rd = 5'd0; bus.exmem_result = 32'h0;
    bus.memwb_regwrite = 1'b0; bus.memwb_rd = 5'd0; bus.memwb_result = 32'h0;
    bus.ALU_OverFlow = 1'b0;
  endtask

  task automatic test_reset();
    bus.stall = 1'b1; bus.flush = 1'b0; clear_fwd();
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 32'hAAAA, 32'hBBBB, 32'hCCCC, 1'b0, 2'b00, 1'b1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; bus.stall = 1'b1;
    tests++; if (bus.ALU_DA !== 32'h0) begin fails++; $display("FAIL reset_da got %h exp 0", bus.ALU_DA); end
    tests++; if (bus.ALU_DB !== 32'h0) begin fails++; $display("FAIL reset_db got %h exp 0", bus.ALU_DB); end
    tests++; if (bus.ALU_Ctrl !== 2'b00) begin fails++; $display("FAIL reset_ctrl got %b exp 00", bus.ALU_Ctrl); end
    tests++; if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", bus.ex_valid); end
    tests++; if (bus.ex_rd !== 5'd0) begin fails++; $display("FAIL reset_rd got %0d exp 0", bus.ex_rd); end
    tests++; if (bus.ex_store_data !== 32'h0) begin fails++; $display("FAIL reset_store got %h exp 0", bus.ex_store_data); end
    tests++; if (bus.ex_wb_en !== 1'b0) begin fails++; $display("FAIL reset_wb got %b exp 0", bus.ex_wb_en); end
    bus.stall = 1'b0;
  endtask

  task automatic test_basic();
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'h0, 1'b0, 2'b00, 1'b1);
    tick();
    tests++; if (bus.ALU_DA !== 32'd5) begin fails++; $display("FAIL basic_da got %h exp 5", bus.ALU_DA); end
    tests++; if (bus.ALU_DB !== 32'd7) begin fails++; $display("FAIL basic_db got %h exp 7", bus.ALU_DB); end
    tests++; if (bus.ALU_Ctrl !== 2'b00) begin fails++; $display("FAIL basic_ctrl got %b exp 00", bus.ALU_Ctrl); end
    tests++; if (bus.ex_wb_en !== 1'b1) begin fails++; $display("FAIL basic_wb got %b exp 1", bus.ex_wb_en); end
    tests++; if (bus.ex_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b exp 1", bus.ex_valid); end
    tests++; if (bus.ex_rd !== 5'd4) begin fails++; $display("FAIL basic_rd got %0d exp 4", bus.ex_rd); end
    tests++; if (bus.ex_store_data !== 32'd7) begin fails++; $display("FAIL basic_store got %h exp 7", bus.ex_store_data); end
  endtask

  task automatic test_fwd_priority();
    set_id(1'b1, 5'd3, 5'd5, 5'd6, 32'h33, 32'h55, 32'h0, 1'b0, 2'b01, 1'b1);
    tick();
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'h11;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'h22;
    #1;
    tests++; if (bus.ALU_DA !== 32'h11) begin fails++; $display("FAIL fwd_exmem got %h exp 11", bus.ALU_DA); end
    tests++; if (bus.ALU_DB !== 32'h55) begin fails++; $display("FAIL fwd_rt_untouched got %h exp 55", bus.ALU_DB); end
    bus.exmem_regwrite = 1'b0;
    #1;
    tests++; if (bus.ALU_DA !== 32'h22) begin fails++; $display("FAIL fwd_memwb got %h exp 22", bus.ALU_DA); end
    bus.memwb_regwrite = 1'b0;
    #1;
    tests++; if (bus.ALU_DA !== 32'h33) begin fails++; $display("FAIL fwd_none got %h exp 33", bus.ALU_DA); end
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'h66;
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd9; bus.exmem_result = 32'h77;
    #1;
    tests++; if (bus.ALU_DB !== 32'h66) begin fails++; $display("FAIL fwd_rt_memwb got %h exp 66", bus.ALU_DB); end
    bus.exmem_rd = 5'd5;
    #1;
    tests++; if (bus.ex_store_data !== 32'h77) begin fails++; $display("FAIL fwd_rt_exmem got %h exp 77", bus.ex_store_data); end
    clear_fwd();
  endtask

  task automatic test_reg0();
    set_id(1'b1, 5'd0, 5'd0, 5'd1, 32'hAB, 32'hCD, 32'h0, 1'b0, 2'b00, 1'b1);
    tick();
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hFF;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'hEE;
    #1;
    tests++; if (bus.ALU_DA !== 32'hAB) begin fails++; $display("FAIL reg0_da got %h exp ab", bus.ALU_DA); end
    tests++; if (bus.ALU_DB !== 32'hCD) begin fails++; $display("FAIL reg0_db got %h exp cd", bus.ALU_DB); end
    clear_fwd();
  endtask

  task automatic test_alusrc();
    set_id(1'b1, 5'd2, 5'd6, 5'd7, 32'h2, 32'h1, 32'hFFFF_FFFC, 1'b1, 2'b00, 1'b1);
    tick();
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd6; bus.exmem_result = 32'h9;
    #1;
    tests++; if (bus.ALU_DB !== 32'hFFFF_FFFC) begin fails++; $display("FAIL alusrc_db got %h exp fffffffc", bus.ALU_DB); end
    tests++; if (bus.ex_store_data !== 32'h9) begin fails++; $display("FAIL alusrc_store got %h exp 9", bus.ex_store_data); end
    clear_fwd();
  endtask

  task automatic test_stall_flush();
    set_id(1'b1, 5'd10, 5'd11, 5'd7, 32'h10, 32'h11, 32'h0, 1'b0, 2'b10, 1'b1);
    tick();
    set_id(1'b1, 5'd12, 5'd13, 5'd8, 32'h20, 32'h21, 32'h0, 1'b0, 2'b00, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.ALU_DA !== 32'h10 || bus.ex_rd !== 5'd7 || bus.ALU_Ctrl !== 2'b10)
        begin fails++; $display("FAIL stall_hold%0d got da=%h rd=%0d ctrl=%b exp da=10 rd=7 ctrl=10", i, bus.ALU_DA, bus.ex_rd, bus.ALU_Ctrl); end
    end
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd10; bus.memwb_result = 32'h44;
    #1;
    tests++; if (bus.ALU_DA !== 32'h44) begin fails++; $display("FAIL stall_fwd got %h exp 44", bus.ALU_DA); end
    clear_fwd();
    bus.flush = 1'b1;
    tick();
    tests++; if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", bus.ex_valid); end
    tests++; if (bus.ex_wb_en !== 1'b0) begin fails++; $display("FAIL flush_wb got %b exp 0", bus.ex_wb_en); end
    tests++; if (bus.ex_rd !== 5'd0 || bus.ALU_DA !== 32'h0 || bus.ALU_Ctrl !== 2'b00)
      begin fails++; $display("FAIL flush_fields got rd=%0d da=%h ctrl=%b exp 0", bus.ex_rd, bus.ALU_DA, bus.ALU_Ctrl); end
    bus.flush = 1'b0; bus.stall = 1'b0;
    tick();
    tests++; if (bus.ALU_DA !== 32'h20 || bus.ex_rd !== 5'd8) begin fails++; $display("FAIL after_flush got da=%h rd=%0d exp da=20 rd=8", bus.ALU_DA, bus.ex_rd); end
  endtask

  task automatic test_overflow();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 2'b00, 1'b1);
    tick();
    bus.ALU_OverFlow = 1'b1; #1;
    tests++; if (bus.ex_wb_en !== 1'b0) begin fails++; $display("FAIL ovf_add got %b exp 0", bus.ex_wb_en); end
    bus.ALU_OverFlow = 1'b0; #1;
    tests++; if (bus.ex_wb_en !== 1'b1) begin fails++; $display("FAIL noovf_add got %b exp 1", bus.ex_wb_en); end
    bus.id_alu_ctrl = 2'b10;
    tick();
    bus.ALU_OverFlow = 1'b1; #1;
    tests++; if (bus.ex_wb_en !== 1'b0) begin fails++; $display("FAIL ovf_sub got %b exp 0", bus.ex_wb_en); end
    bus.ALU_OverFlow = 1'b0;
    bus.id_alu_ctrl = 2'b01;
    tick();
    bus.ALU_OverFlow = 1'b1; #1;
    tests++; if (bus.ex_wb_en !== 1'b1) begin fails++; $display("FAIL ovf_or got %b exp 1", bus.ex_wb_en); end
    bus.ALU_OverFlow = 1'b0;
    bus.id_regwrite = 1'b0;
    tick();
    tests++; if (bus.ex_wb_en !== 1'b0) begin fails++; $display("FAIL no_regwrite got %b exp 0", bus.ex_wb_en); end
  endtask

  task automatic test_reset_midstall();
    set_id(1'b1, 5'd4, 5'd5, 5'd9, 32'h99, 32'h98, 32'h0, 1'b0, 2'b00, 1'b1);
    tick();
    bus.stall = 1'b1; bus.flush = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tests++; if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0) begin fails++; $display("FAIL rst_midstall got valid=%b rd=%0d exp 0/0", bus.ex_valid, bus.ex_rd); end
    rst = 1'b0; bus.stall = 1'b0;
    set_id(1'b1, 5'd6, 5'd7, 5'd10, 32'h5A, 32'h5B, 32'h0, 1'b0, 2'b00, 1'b1);
    tick();
    tests++; if (bus.ex_valid !== 1'b1 || bus.ALU_DA !== 32'h5A || bus.ex_rd !== 5'd10)
      begin fails++; $display("FAIL post_rst_accept got valid=%b da=%h rd=%0d exp 1/5a/10", bus.ex_valid, bus.ALU_DA, bus.ex_rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rsd [3] = '{32'h100, 32'h200, 32'h300};
    logic [4:0]  rds [3] = '{5'd21, 5'd22, 5'd23};
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd1, 5'd2, rds[i], rsd[i], rsd[i] + 32'h1, 32'h0, 1'b0, 2'b00, 1'b1);
      tick();
      tests++; if (bus.ALU_DA !== rsd[i] || bus.ALU_DB !== rsd[i] + 32'h1 || bus.ex_rd !== rds[i])
        begin fails++; $display("FAIL b2b%0d got da=%h db=%h rd=%0d exp da=%h db=%h rd=%0d", i, bus.ALU_DA, bus.ALU_DB, bus.ex_rd, rsd[i], rsd[i] + 32'h1, rds[i]); end
    end
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
    tick();
    tests++; if (bus.ex_valid !== 1'b0 || bus.ex_wb_en !== 1'b0) begin fails++; $display("FAIL b2b_invalid got valid=%b wb=%b exp 0/0", bus.ex_valid, bus.ex_wb_en); end
  endtask

  initial begin
    rst = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    clear_fwd();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_fwd_priority();
    test_reg0();
    test_alusrc();
    test_stall_flush();
    test_overflow();
    test_reset_midstall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
